sdram_bram_responder: RTL

//  Responder (controller) end of the SDRAM burst user interface, backed by on-chip block RAM.

---
 rtl/sdram_bram_pkg.sv | 20 ++
 rtl/sdram_bram_responder_if.sv | 34 +++
 rtl/sdram_bram_sdp.sv | 36 +++
 rtl/sdram_bram_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sdram_bram_pkg.sv
// Shared types for the BRAM-backed SDRAM burst responder: FSM states, served-type enum
// and the helper that picks the first burst state once any wait has elapsed.
package sdram_bram_pkg;

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_DATA, WR_LAST, RD_WAIT, RD_DATA, RD_LAST, FINISH
  } state_e;

  typedef enum logic {
    SERVED_READ  = 1'b0,
    SERVED_WRITE = 1'b1
  } served_e;

  // A zero-length burst goes straight to its LAST state so finish keeps its fixed offset.
  function automatic state_e burst_entry(input logic is_wr, input logic no_data);
    if (is_wr) return no_data ? WR_LAST : WR_DATA;
    return no_data ? RD_LAST : RD_DATA;
  endfunction

endpackage

// File: rtl/sdram_bram_responder_if.sv
// SDRAM burst user interface between an initiator (master) and a responder (slave).
interface sdram_bram_responder_if #(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int BUSRT_WIDTH    = 6
);
  logic                      i_rd_burst_req;
  logic [BUSRT_WIDTH-1:0]    i_rd_burst_len;
  logic [ADDR_WIDTH-1:0]     i_rd_burst_addr;
  logic                      o_rd_burst_data_valid;
  logic [MEM_DATA_WIDTH-1:0] o_rd_burst_data;
  logic                      o_rd_burst_finish;
  logic                      i_wr_burst_req;
  logic [BUSRT_WIDTH-1:0]    i_wr_burst_len;
  logic [ADDR_WIDTH-1:0]     i_wr_burst_addr;
  logic                      o_wr_burst_data_req;
  logic [MEM_DATA_WIDTH-1:0] i_wr_burst_data;
  logic                      o_wr_burst_finish;
  logic                      o_busy;

  modport slave (
    input  i_rd_burst_req, i_rd_burst_len, i_rd_burst_addr,
    output o_rd_burst_data_valid, o_rd_burst_data, o_rd_burst_finish,
    input  i_wr_burst_req, i_wr_burst_len, i_wr_burst_addr, i_wr_burst_data,
    output o_wr_burst_data_req, o_wr_burst_finish, o_busy
  );

  modport master (
    output i_rd_burst_req, i_rd_burst_len, i_rd_burst_addr,
    input  o_rd_burst_data_valid, o_rd_burst_data, o_rd_burst_finish,
    output i_wr_burst_req, i_wr_burst_len, i_wr_burst_addr, i_wr_burst_data,
    input  o_wr_burst_data_req, o_wr_burst_finish, o_busy
  );
endinterface

// File: rtl/sdram_bram_sdp.sv
// Simple dual-port single-clock RAM: one write port, one registered read port (latency 1).
module sdram_bram_sdp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Output register holds its value between reads; it is the only part that resets.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_bram_responder.sv
// BRAM-backed responder for the SDRAM burst interface, with SDRAM-like handshake timing.
// Define SDRAM_RSP_WAIT_EN to insert ACCESS_LATENCY wait cycles after each accept.
module sdram_bram_responder
  import sdram_bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int BUSRT_WIDTH    = 6,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  sdram_bram_responder_if.slave bus
);

  localparam int CW = BUSRT_WIDTH + 1;

  state_e                    state_q, state_d;
  served_e                   last_q, last_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wr_en_q, wr_en_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      serve_wr, data_req, rd_en;
  logic                      unused_ok;

`ifdef SDRAM_RSP_WAIT_EN
  localparam int WAIT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;
  assign unused_ok = ^{bus.i_wr_burst_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                       bus.i_rd_burst_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};
`else
  assign unused_ok = ^{bus.i_wr_burst_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                       bus.i_rd_burst_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                       ACCESS_LATENCY[0]};
`endif

  // Round-robin: with both requests pending, serve the type opposite the last one served.
  assign serve_wr = bus.i_wr_burst_req && (!bus.i_rd_burst_req || last_q == SERVED_READ);
  assign data_req = (state_q == WR_DATA);
  assign rd_en    = (state_q == RD_DATA);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_en_d  = data_req;
    rd_vld_d = rd_en;
`ifdef SDRAM_RSP_WAIT_EN
    wait_d   = wait_q;
`endif
    if (wr_en_q || rd_en) addr_d = addr_q + MEM_ADDR_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (bus.i_wr_burst_req || bus.i_rd_burst_req) begin
          last_d = serve_wr ? SERVED_WRITE : SERVED_READ;
          cnt_d  = serve_wr ? {1'b0, bus.i_wr_burst_len} : {1'b0, bus.i_rd_burst_len};
          addr_d = serve_wr ? bus.i_wr_burst_addr[MEM_ADDR_WIDTH-1:0]
                            : bus.i_rd_burst_addr[MEM_ADDR_WIDTH-1:0];
          state_d = burst_entry(serve_wr, cnt_d == '0);
`ifdef SDRAM_RSP_WAIT_EN
          if (ACCESS_LATENCY != 0) begin
            state_d = serve_wr ? WR_WAIT : RD_WAIT;
            wait_d  = WAIT_W'(ACCESS_LATENCY - 1);
          end
`endif
        end
      end
`ifdef SDRAM_RSP_WAIT_EN
      WR_WAIT, RD_WAIT: begin
        if (wait_q == '0) state_d = burst_entry(state_q == WR_WAIT, cnt_q == '0);
        else              wait_d  = wait_q - WAIT_W'(1);
      end
`endif
      WR_DATA: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = WR_LAST;
      end
      RD_DATA: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RD_LAST;
      end
      WR_LAST, RD_LAST: state_d = FINISH;
      FINISH:           state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q  <= IDLE;
      last_q   <= SERVED_READ;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      rd_vld_q <= rd_vld_d;
    end
  end

`ifdef SDRAM_RSP_WAIT_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) wait_q <= '0;
    else              wait_q <= wait_d;
  end
`endif

  // Write data arrives one cycle after data_req, so the write strobe is data_req delayed.
  sdram_bram_sdp #(
    .ADDR_W (MEM_ADDR_WIDTH),
    .DATA_W (MEM_DATA_WIDTH)
  ) u_ram (
    .clk   (i_sys_clk),
    .rst_n (i_sys_rst_n),
    .we    (wr_en_q),
    .waddr (addr_q),
    .wdata (bus.i_wr_burst_data),
    .re    (rd_en),
    .raddr (addr_q),
    .rdata (bus.o_rd_burst_data)
  );

  assign bus.o_wr_burst_data_req   = data_req;
  assign bus.o_rd_burst_data_valid = rd_vld_q;
  assign bus.o_wr_burst_finish     = (state_q == FINISH) && (last_q == SERVED_WRITE);
  assign bus.o_rd_burst_finish     = (state_q == FINISH) && (last_q == SERVED_READ);
  assign bus.o_busy                = (state_q != IDLE);

endmodule
